// File: rtl/traffic_light_controller.sv
`timescale 1ns/1ps
// traffic_light_controller
//
// Two-road intersection controller. The main road rests on green. A side-road
// request (a single-cycle pulse from the car detector) is latched. After a
// guaranteed minimum main green, it triggers one full side-road service cycle:
// main yellow, all-red, side green, side yellow, all-red, then back to main green.
//
// Ports
//   clk        in  1  single clock, rising edge
//   rst        in  1  asynchronous, active-high reset
//   req        in  1  side-road request pulse; any cycle high counts as one request
//   main_lamp  out 3  {red, yellow, green}, exactly one bit set
//   side_lamp  out 3  {red, yellow, green}, exactly one bit set
//   pending    out 1  latched side request that has not been served yet
//   phase      out 3  state code for debug/trace (MG=0 .. AR2=5)
//
// Parameters: every dwell is in clock cycles, must be >= 1, and must be <= 2**CW.

module traffic_light_controller #(
  parameter int MIN_GREEN    = 8,
  parameter int YELLOW_T     = 3,
  parameter int ALL_RED_T    = 1,
  parameter int SIDE_GREEN_T = 5,
  parameter int CW           = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  output logic [2:0] main_lamp,
  output logic [2:0] side_lamp,
  output logic       pending,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    MG  = 3'd0,
    MY  = 3'd1,
    AR1 = 3'd2,
    SG  = 3'd3,
    SY  = 3'd4,
    AR2 = 3'd5
  } state_t;

  // Terminal timer values: a timed state exits on the edge where t reaches these.
  localparam logic [CW-1:0] MG_LAST = CW'(MIN_GREEN - 1);
  localparam logic [CW-1:0] Y_LAST  = CW'(YELLOW_T - 1);
  localparam logic [CW-1:0] AR_LAST = CW'(ALL_RED_T - 1);
  localparam logic [CW-1:0] SG_LAST = CW'(SIDE_GREEN_T - 1);

  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b001;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] t;
  logic [CW-1:0] t_next;
  logic          pending_next;

  // Lamp pattern {main, side} for a state. Codes outside the six legal states
  // never reach this function, but they still decode to the main-green rest pattern.
  function automatic logic [5:0] lamp_decode(input state_t s);
    case (s)
      MG:      lamp_decode = {GREEN,  RED};
      MY:      lamp_decode = {YELLOW, RED};
      AR1:     lamp_decode = {RED,    RED};
      SG:      lamp_decode = {RED,    GREEN};
      SY:      lamp_decode = {RED,    YELLOW};
      AR2:     lamp_decode = {RED,    RED};
      default: lamp_decode = {GREEN,  RED};
    endcase
  endfunction

  // Next-state, timer and request-latch logic.
  always_comb begin
    // NOTE: every signal is given a default first so no path leaves it
    // unassigned; an unassigned path would infer a latch.
    state_next   = state;
    t_next       = t + CW'(1);
    pending_next = pending;

    case (state)
      MG: begin
        // Saturate at the minimum dwell so a long idle green never wraps the timer.
        if (t == MG_LAST) begin
          t_next = t;
          if (pending || req) begin
            state_next = MY;
            t_next     = '0;
          end
        end
      end
      MY:  if (t == Y_LAST)  begin state_next = AR1; t_next = '0; end
      AR1: if (t == AR_LAST) begin state_next = SG;  t_next = '0; end
      SG:  if (t == SG_LAST) begin state_next = SY;  t_next = '0; end
      SY:  if (t == Y_LAST)  begin state_next = AR2; t_next = '0; end
      AR2: if (t == AR_LAST) begin state_next = MG;  t_next = '0; end
      default: begin
        // Illegal codes 6/7 recover to main green.
        state_next = MG;
        t_next     = '0;
      end
    endcase

    // The SG-entry edge serves the request and wins over a coincident req.
    // A req seen during SG is ignored because that road is already being served.
    if (state == AR1 && state_next == SG) begin
      pending_next = 1'b0;
    end else if (req && state != SG) begin
      pending_next = 1'b1;
    end
  end

  // Lamps and phase are registered from the next state. They therefore always
  // match the registered state and cannot glitch or show two bits set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= MG;
      t         <= '0;
      pending   <= 1'b0;
      main_lamp <= GREEN;
      side_lamp <= RED;
      phase     <= 3'd0;
    end else begin
      // NOTE: non-blocking assignments so that every register samples the
      // values from before the edge, whatever order the statements run in.
      state                  <= state_next;
      t                      <= t_next;
      pending                <= pending_next;
      {main_lamp, side_lamp} <= lamp_decode(state_next);
      phase                  <= state_next;
    end
  end

endmodule

// File: tb/tb_traffic_light_controller.sv
`timescale 1ns/1ps
// tb_traffic_light_controller
//
// Directed bench for traffic_light_controller with its default parameters.
// A cycle-level reference model pushes the expected lamp/pending/phase values
// into a scoreboard queue when each stimulus cycle is driven. Each entry is
// popped and compared when the DUT output settles after the clock edge.
// Directed duration checks cover the dwell of each phase.

module tb_traffic_light_controller;

  localparam int MIN_GREEN    = 8;
  localparam int YELLOW_T     = 3;
  localparam int ALL_RED_T    = 1;
  localparam int SIDE_GREEN_T = 5;
  localparam int CW           = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       req;
  logic [2:0] main_lamp;
  logic [2:0] side_lamp;
  logic       pending;
  logic [2:0] phase;

  traffic_light_controller #(
    .MIN_GREEN   (MIN_GREEN),
    .YELLOW_T    (YELLOW_T),
    .ALL_RED_T   (ALL_RED_T),
    .SIDE_GREEN_T(SIDE_GREEN_T),
    .CW          (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .main_lamp(main_lamp),
    .side_lamp(side_lamp),
    .pending  (pending),
    .phase    (phase)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] main;
    logic [2:0] side;
    logic       pend;
    logic [2:0] ph;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: phase index, cycles spent in phase, latched request.
  int   m_state;
  int   m_cnt;
  logic m_pend;

  function automatic exp_t expect_for(input int s, input logic p);
    exp_t e;
    e.pend = p;
    e.ph   = 3'(s);
    case (s)
      0:       begin e.main = 3'b001; e.side = 3'b100; end
      1:       begin e.main = 3'b010; e.side = 3'b100; end
      3:       begin e.main = 3'b100; e.side = 3'b001; end
      4:       begin e.main = 3'b100; e.side = 3'b010; end
      default: begin e.main = 3'b100; e.side = 3'b100; end
    endcase
    return e;
  endfunction

  function automatic int dwell_of(input int s);
    case (s)
      1, 4:    return YELLOW_T;
      2, 5:    return ALL_RED_T;
      3:       return SIDE_GREEN_T;
      default: return MIN_GREEN;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_cnt   = 0;
    m_pend  = 1'b0;
    sb.delete();
  endtask

  task automatic model_step(input logic r);
    logic adv;
    if (m_state == 0) adv = (m_cnt >= MIN_GREEN - 1) && (m_pend || r);
    else              adv = (m_cnt + 1 == dwell_of(m_state));
    if (m_state == 2 && adv)      m_pend = 1'b0;
    else if (r && m_state != 3)   m_pend = 1'b1;
    if (adv) begin
      m_state = (m_state + 1) % 6;
      m_cnt   = 0;
    end else begin
      m_cnt++;
    end
    sb.push_back(expect_for(m_state, m_pend));
  endtask

  // One clock cycle: drive at the falling edge, compare at the next falling edge.
  task automatic step(input logic r);
    exp_t e;
    req = r;
    model_step(r);
    @(posedge clk);
    @(negedge clk);
    e = sb.pop_front();
    check("sb_main_lamp", 32'(main_lamp), 32'(e.main));
    check("sb_side_lamp", 32'(side_lamp), 32'(e.side));
    check("sb_pending",   32'(pending),   32'(e.pend));
    check("sb_phase",     32'(phase),     32'(e.ph));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_main"},    32'(main_lamp), 32'h1);
    check({tag, "_side"},    32'(side_lamp), 32'h4);
    check({tag, "_pending"}, 32'(pending),   32'h0);
    check({tag, "_phase"},   32'(phase),     32'h0);
  endtask

  // Reset applied away from the clock edge; outputs must respond at once.
  task automatic do_reset(input string tag);
    req = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_values(tag);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic run_to(input logic [2:0] ph, input int max, output int n);
    n = 0;
    while (phase !== ph && n < max) begin
      step(1'b0);
      n++;
    end
    check("reach_phase", 32'(phase), 32'(ph));
  endtask

  task automatic dwell(input logic [2:0] ph, output int n);
    n = 0;
    while (phase === ph && n < 100) begin
      step(1'b0);
      n++;
    end
  endtask

  initial begin
    int n;
    rst = 1'b1;
    req = 1'b0;
    model_reset();

    // Reset and idle.
    repeat (10) @(negedge clk);
    check_reset_values("rst_hold");
    rst = 1'b0;
    repeat (50) step(1'b0);

    // Early request at MG t=2.
    do_reset("rst_early");
    step(1'b0);
    step(1'b0);
    step(1'b1);
    check("pending_rise", 32'(pending), 32'h1);
    run_to(3'd1, 20, n);
    check("mg_to_my_cycles", 32'(n + 3), 32'(MIN_GREEN));
    check("my_main_lamp", 32'(main_lamp), 32'h2);
    dwell(3'd1, n); check("my_dwell",  32'(n), 32'(YELLOW_T));
    dwell(3'd2, n); check("ar1_dwell", 32'(n), 32'(ALL_RED_T));
    check("sg_side_lamp", 32'(side_lamp), 32'h1);
    check("sg_pending",   32'(pending),   32'h0);
    dwell(3'd3, n); check("sg_dwell",  32'(n), 32'(SIDE_GREEN_T));
    dwell(3'd4, n); check("sy_dwell",  32'(n), 32'(YELLOW_T));
    dwell(3'd5, n); check("ar2_dwell", 32'(n), 32'(ALL_RED_T));
    check("back_to_mg", 32'(phase), 32'h0);

    // Late and repeated requests after a long idle green.
    repeat (20) step(1'b0);
    step(1'b1);
    check("late_my_next_cycle", 32'(main_lamp), 32'h2);
    step(1'b1);
    step(1'b1);
    run_to(3'd0, 40, n);
    repeat (30) step(1'b0);
    check("single_cycle_phase",   32'(phase),   32'h0);
    check("single_cycle_pending", 32'(pending), 32'h0);

    // Request during SG is ignored.
    step(1'b1);
    run_to(3'd3, 20, n);
    step(1'b1);
    check("sg_req_ignored", 32'(pending), 32'h0);
    run_to(3'd0, 40, n);
    repeat (40) step(1'b0);
    check("sg_req_mg_hold", 32'(phase), 32'h0);

    // Request during SY is served after a full minimum green.
    step(1'b1);
    run_to(3'd4, 20, n);
    step(1'b1);
    check("sy_req_pending", 32'(pending), 32'h1);
    dwell(3'd4, n);
    check("ar2_pending", 32'(pending), 32'h1);
    dwell(3'd5, n);
    dwell(3'd0, n);
    check("mg_min_dwell", 32'(n), 32'(MIN_GREEN));
    check("second_cycle_my", 32'(phase), 32'h1);

    // Reset in the middle of SG at t=2.
    run_to(3'd3, 20, n);
    step(1'b0);
    step(1'b0);
    do_reset("rst_mid_sg");
    repeat (30) step(1'b0);
    check("post_reset_idle", 32'(phase), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
